// File: rtl/add_sub_seq_if.sv
// add_sub_seq_if: request/result bundle for the serial nibble adder/subtractor.
// Two requesters share the request side; one consumer takes results.
// Optional feature macro: ADD_SUB_SEQ_OVF_EN adds the res_ovf signal.
interface add_sub_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic [1:0]     req_valid;
    logic [1:0]     req_op;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_sum;
    logic           res_cout;
    logic           res_id;
    logic           busy;
`ifdef ADD_SUB_SEQ_OVF_EN
    logic           res_ovf;
`endif

    modport master (
        output req_valid, req_op, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_cout, res_id, busy
`ifdef ADD_SUB_SEQ_OVF_EN
        , input res_ovf
`endif
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_cout, res_id, busy
`ifdef ADD_SUB_SEQ_OVF_EN
        , output res_ovf
`endif
    );
endinterface

// File: rtl/add_sub_seq.sv
// add_sub_seq: two-requester arbitrated add/subtract unit that runs one 4-bit
// slice serially over NIBBLES nibbles, LSB first, then holds the result until
// the consumer accepts it.
// Optional feature macro: ADD_SUB_SEQ_OVF_EN adds res_ovf (signed overflow).
module add_sub_seq #(
    parameter int NIBBLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    add_sub_seq_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
`ifdef ADD_SUB_SEQ_OVF_EN
    localparam int SW = 6;
`else
    localparam int SW = 5;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The single 4-bit slice: B is inverted for subtract, carry-in explicit.
    // Returns {[carry into bit 3,] carry out, sum[3:0]}.
    function automatic logic [SW-1:0] slice_addsub(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       op,
        input logic       cin
    );
        logic [3:0] bx;
        logic [3:0] low;
        logic [1:0] top;
        bx  = b ^ {4{op}};
        low = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
        top = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, low[3]};
`ifdef ADD_SUB_SEQ_OVF_EN
        slice_addsub = {low[3], top[1], top[0], low[2:0]};
`else
        slice_addsub = {top[1], top[0], low[2:0]};
`endif
    endfunction

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          op_q, op_d;
    logic          id_q, id_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          res_valid_q, res_valid_d;
    logic [W-1:0]  res_sum_q, res_sum_d;
    logic          res_cout_q, res_cout_d;
    logic          res_id_q, res_id_d;
`ifdef ADD_SUB_SEQ_OVF_EN
    logic          res_ovf_q, res_ovf_d;
`endif
    logic          grant_s;
    logic [1:0]    req_ready_s;
    logic          cin_s;
    logic [SW-1:0] slice_s;

    // Next-state logic: arbitration in IDLE, one nibble per CALC cycle, hold in DONE.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_id_d    = res_id_q;
`ifdef ADD_SUB_SEQ_OVF_EN
        res_ovf_d   = res_ovf_q;
`endif
        grant_s     = 1'b0;
        req_ready_s = 2'b00;
        if (cnt_q == CNT_ZERO) begin
            cin_s = op_q;
        end else begin
            cin_s = carry_q;
        end
        slice_s = slice_addsub(a_q[3:0], b_q[3:0], op_q, cin_s);

        case (state_q)
            IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    // Both asking: the one not served last wins.
                    if (bus.req_valid == 2'b11) begin
                        grant_s = ~last_q;
                    end else begin
                        grant_s = bus.req_valid[1];
                    end
                    if (grant_s) begin
                        req_ready_s = 2'b10;
                        a_d         = bus.req_a[2*W-1:W];
                        b_d         = bus.req_b[2*W-1:W];
                        op_d        = bus.req_op[1];
                    end else begin
                        req_ready_s = 2'b01;
                        a_d         = bus.req_a[W-1:0];
                        b_d         = bus.req_b[W-1:0];
                        op_d        = bus.req_op[0];
                    end
                    id_d    = grant_s;
                    last_d  = grant_s;
                    cnt_d   = CNT_ZERO;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // Result nibbles shift into the top of A as operand nibbles leave the bottom.
                a_d     = {slice_s[3:0], a_q[W-1:4]};
                b_d     = {4'h0, b_q[W-1:4]};
                carry_d = slice_s[4];
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == LAST_NIB) begin
                    res_sum_d   = {slice_s[3:0], a_q[W-1:4]};
                    res_cout_d  = slice_s[4];
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
`ifdef ADD_SUB_SEQ_OVF_EN
                    res_ovf_d   = slice_s[5] ^ slice_s[4];
`endif
                    state_d     = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            op_q        <= 1'b0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= CNT_ZERO;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= {W{1'b0}};
            res_cout_q  <= 1'b0;
            res_id_q    <= 1'b0;
`ifdef ADD_SUB_SEQ_OVF_EN
            res_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_id_q    <= res_id_d;
`ifdef ADD_SUB_SEQ_OVF_EN
            res_ovf_q   <= res_ovf_d;
`endif
        end
    end

    // The grant pulse is qualified by rst_n so it is low while reset is held.
    assign bus.req_ready = req_ready_s & {2{rst_n}};
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = (state_q != IDLE);
`ifdef ADD_SUB_SEQ_OVF_EN
    assign bus.res_ovf   = res_ovf_q;
`endif
endmodule
